sr_shift_ctrl: RTL and testbench
================================

Name: sr_shift_ctrl

Overview:
- Sequencer that owns a WIDTH-bit shift register and runs one full-duplex serial transfer per accepted parallel word.
- The word is loaded through a valid/ready handshake and shifted out MSB-first on sd_o. At the same time, x_i is shifted into the LSB.
- When WIDTH bits have moved, the captured word is presented on rx_data_o with a one-cycle rx_valid_o pulse.
- Sits between a parallel producer/consumer and a serial link, with a programmable bit period.

Parameters:
- WIDTH, 4, shift register / word width in bits; WIDTH >= 2.
- DIV, 1, clock cycles per serial bit; DIV >= 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- tx_valid_i  in  1  parallel word available.
- tx_data_i  in  WIDTH  parallel word; held stable by the producer until accepted.
- tx_ready_o  out  1  controller can accept a word.
- x_i  in  1  serial input, sampled on bit ticks.
- sd_o  out  1  serial output, equal to sr_o[WIDTH-1].
- sr_o  out  WIDTH  current shift register contents.
- busy_o  out  1  high in SHIFT or DONE.
- rx_valid_o  out  1  one-cycle pulse; rx_data_o is valid.
- rx_data_o  out  WIDTH  last captured word; held until the next completion.
- abort_i  in  1  cancels a transfer in progress.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state<=IDLE; sr_o, rx_data_o, bit_cnt, div_cnt <= 0; rx_valid_o <= 0.
  - tx_ready_o is forced to 0 while reset is low.
- Counters:
  - bit_cnt is clog2(WIDTH) bits.
  - div_cnt is max(1, clog2(DIV)) bits.
  - Both wrap only under explicit control; there is no free-running wrap.
- tx_ready_o = (state==IDLE) && reset. busy_o = (state!=IDLE).
- IDLE:
  - On tx_valid_i && tx_ready_o: sr<=tx_data_i, bit_cnt<=0, div_cnt<=0, go to SHIFT.
  - Otherwise sr holds.
  - abort_i is ignored.
- SHIFT:
  - A bit tick occurs when div_cnt==DIV-1. div_cnt increments otherwise and clears on a tick.
  - On each tick: sr<={sr[WIDTH-2:0], x_i}, bit_cnt++.
  - On the tick where bit_cnt==WIDTH-1:
    - rx_data_o<={sr[WIDTH-2:0], x_i}
    - rx_valid_o<=1
    - go to DONE.
  - With DIV=1, a tick occurs every cycle.
- DONE:
  - Lasts exactly one cycle with rx_valid_o=1 and tx_ready_o=0.
  - Then go to IDLE with rx_valid_o<=0.
- Latency, with acceptance at edge 0:
  - SHIFT occupies cycles 1..WIDTH*DIV.
  - sd_o shows bit WIDTH-1-k during cycles k*DIV+1 .. (k+1)*DIV.
  - rx_valid_o is high in cycle WIDTH*DIV+1.
  - The next acceptance is possible at the end of cycle WIDTH*DIV+2.
- tx_valid_i while not ready: ignored. A changing tx_data_i has no effect.
- abort_i in SHIFT:
  - Next edge: state<=IDLE, sr<=0, counters<=0.
  - No rx_valid_o; rx_data_o keeps its old value.
  - Abort has priority over a simultaneous final tick.
- abort_i in DONE: ignored; the pulse completes.
- Reset mid-transfer: reset values apply at the next edge regardless of state or abort_i.

Test Plan (WIDTH=4 unless noted):
1. DIV=1, load 4'b1011, x_i=0,1,1,0 on cycles 1..4 -> sd_o=1,0,1,1 on cycles 1..4; rx_valid_o high only in cycle 5; rx_data_o=4'b0110; tx_ready_o returns high in cycle 6.
2. DIV=3, load 4'b1100, x_i held 1 -> sd_o=1 for cycles 1-6, 0 for cycles 7-12; rx_valid_o in cycle 13; rx_data_o=4'b1111.
3. DIV=1, load 4'b1111, assert abort_i in cycle 2 -> IDLE in cycle 3; sr_o=0; tx_ready_o=1; rx_valid_o never asserts; rx_data_o unchanged. Repeat with abort_i on the final tick (cycle 4) -> rx_valid_o still never asserts.
4. Drive reset=0 during SHIFT cycle 2 -> at the next edge sr_o=0, rx_valid_o=0, busy_o=0; tx_ready_o=0 while reset is low and 1 after release.
5. Back-to-back, DIV=1, tx_valid_i held high with 4'hA then 4'h5 -> first accepted at edge 0, second at the end of cycle 6; tx_ready_o low in cycles 1-5; two rx_valid_o pulses 6 cycles apart.
6. During SHIFT, drive tx_valid_i=1 with tx_data_i=4'h0 -> no effect on sr_o or sd_o; the transfer completes with the original data.

Source files
------------

// File: rtl/sr_shift_ctrl.sv
// Full-duplex shift-register sequencer: loads a parallel word, shifts it out
// MSB-first at a programmable bit period while capturing x_i into the LSB.
module sr_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid_i,
  input  logic [WIDTH-1:0] tx_data_i,
  output logic             tx_ready_o,
  input  logic             x_i,
  output logic             sd_o,
  output logic [WIDTH-1:0] sr_o,
  output logic             busy_o,
  output logic             rx_valid_o,
  output logic [WIDTH-1:0] rx_data_o,
  input  logic             abort_i,
  output logic [1:0]       state_dbg
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [WIDTH-1:0] shifted;

  // Handshake: a word transfers on any rising edge where tx_valid_i and
  // tx_ready_o are both high; the producer holds tx_data_i until then.
  assign tx_ready_o = (state == IDLE) && reset;
  assign busy_o     = (state != IDLE);
  assign sd_o       = sr_o[WIDTH-1];
  assign state_dbg  = state;
  assign tick       = (div_cnt == LAST_DIV);
  assign shifted    = {sr_o[WIDTH-2:0], x_i};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      sr_o       <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
    end else begin
      rx_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid_i && tx_ready_o) begin
            sr_o    <= tx_data_i;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Abort wins even over the final tick, so no partial word escapes.
          if (abort_i) begin
            state   <= IDLE;
            sr_o    <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
          end else if (tick) begin
            div_cnt <= '0;
            sr_o    <= shifted;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              rx_data_o  <= shifted;
              rx_valid_o <= 1'b1;
              state      <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_shift_ctrl.sv
// Bench for sr_shift_ctrl: one DUT with DIV=1 and one with DIV=3 share stimulus;
// sel routes handshake/abort to one of them and picks which outputs are observed.
module tb_sr_shift_ctrl;
  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         tx_valid;
  logic [W-1:0] tx_data;
  logic         x;
  logic         abort;
  int           sel;

  logic         tx_valid_a, tx_valid_b, abort_a, abort_b;
  logic         ready_a, sd_a, busy_a, rxv_a, ready_b, sd_b, busy_b, rxv_b;
  logic [W-1:0] sr_a, rxd_a, sr_b, rxd_b;
  logic [1:0]   st_a, st_b;

  assign tx_valid_a = tx_valid && (sel == 0);
  assign tx_valid_b = tx_valid && (sel == 1);
  assign abort_a    = abort && (sel == 0);
  assign abort_b    = abort && (sel == 1);

  sr_shift_ctrl #(.WIDTH(W), .DIV(1)) dut_a (
    .clk(clk), .reset(reset), .tx_valid_i(tx_valid_a), .tx_data_i(tx_data),
    .tx_ready_o(ready_a), .x_i(x), .sd_o(sd_a), .sr_o(sr_a), .busy_o(busy_a),
    .rx_valid_o(rxv_a), .rx_data_o(rxd_a), .abort_i(abort_a), .state_dbg(st_a)
  );

  sr_shift_ctrl #(.WIDTH(W), .DIV(3)) dut_b (
    .clk(clk), .reset(reset), .tx_valid_i(tx_valid_b), .tx_data_i(tx_data),
    .tx_ready_o(ready_b), .x_i(x), .sd_o(sd_b), .sr_o(sr_b), .busy_o(busy_b),
    .rx_valid_o(rxv_b), .rx_data_o(rxd_b), .abort_i(abort_b), .state_dbg(st_b)
  );

  logic         o_ready, o_sd, o_busy, o_rxv;
  logic [W-1:0] o_sr, o_rxd;

  always_comb begin
    o_ready = ready_a; o_sd = sd_a; o_busy = busy_a; o_rxv = rxv_a;
    o_sr = sr_a; o_rxd = rxd_a;
    if (sel == 1) begin
      o_ready = ready_b; o_sd = sd_b; o_busy = busy_b; o_rxv = rxv_b;
      o_sr = sr_b; o_rxd = rxd_b;
    end
  end

  // scoreboard state
  int           assert_cnt = 0;
  int           fail_cnt   = 0;
  logic [W-1:0] last_rx [2];

  // reference model
  function automatic int div_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  // Register after n bit shifts: data moved up n places, the first n serial
  // bits (xb MSB = first bit received) filling the bottom.
  function automatic logic [W-1:0] model_sr(input logic [W-1:0] d,
                                            input logic [W-1:0] xb, input int n);
    int v;
    v = (int'(d) << n) | (int'(xb) >> (W - n));
    return v[W-1:0];
  endfunction

  task automatic wait_ready(input string name);
    int waited = 0;
    while (o_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    assert_cnt++;
    if (waited >= 50) begin
      fail_cnt++;
      $display("FAIL %s ready_timeout: tx_ready got %b want 1 within 50 cycles", name, o_ready);
    end
  endtask

  // One transfer on the selected DUT; abort_cycle 0 means no abort.
  task automatic run_transfer(input logic [W-1:0] d, input logic [W-1:0] xb,
                              input int abort_cycle, input bit noise, input string name);
    int           dv;
    int           total;
    int           k;
    logic [W-1:0] esr;
    dv    = div_of(sel);
    total = W * dv;
    tx_data  = d;
    tx_valid = 1'b1;
    wait_ready(name);
    @(posedge clk); #1;
    tx_valid = noise;
    tx_data  = noise ? '0 : d;
    for (int c = 1; c <= total; c++) begin
      k     = (c - 1) / dv;
      x     = xb[W-1-k];
      abort = (c == abort_cycle);
      @(negedge clk);
      esr = model_sr(d, xb, k);
      assert_cnt++;
      if ({o_sr, o_sd, o_busy, o_ready, o_rxv} !== {esr, esr[W-1], 1'b1, 1'b0, 1'b0}) begin
        fail_cnt++;
        $display("FAIL %s shift cycle %0d: sr/sd/busy/ready/rxv got %b want %b", name, c,
                 {o_sr, o_sd, o_busy, o_ready, o_rxv}, {esr, esr[W-1], 1'b1, 1'b0, 1'b0});
      end
      @(posedge clk); #1;
      if (c == abort_cycle) break;
    end
    abort    = 1'b0;
    tx_valid = 1'b0;
    x        = 1'b0;
    @(negedge clk);
    if (abort_cycle != 0) begin
      assert_cnt++;
      if ({o_sr, o_busy, o_ready, o_rxv, o_rxd} !== {{W{1'b0}}, 1'b0, 1'b1, 1'b0, last_rx[sel]}) begin
        fail_cnt++;
        $display("FAIL %s after_abort: sr/busy/ready/rxv/rxd got %b want %b", name,
                 {o_sr, o_busy, o_ready, o_rxv, o_rxd},
                 {{W{1'b0}}, 1'b0, 1'b1, 1'b0, last_rx[sel]});
      end
      @(posedge clk); #1;
      @(negedge clk);
      assert_cnt++;
      if (o_rxv !== 1'b0) begin
        fail_cnt++;
        $display("FAIL %s abort_no_pulse: rx_valid got %b want 0", name, o_rxv);
      end
    end else begin
      assert_cnt++;
      if ({o_rxv, o_rxd, o_busy, o_ready} !== {1'b1, xb, 1'b1, 1'b0}) begin
        fail_cnt++;
        $display("FAIL %s done: rxv/rxd/busy/ready got %b want %b", name,
                 {o_rxv, o_rxd, o_busy, o_ready}, {1'b1, xb, 1'b1, 1'b0});
      end
      last_rx[sel] = xb;
      @(posedge clk); #1;
      @(negedge clk);
      assert_cnt++;
      if ({o_rxv, o_rxd, o_busy, o_ready} !== {1'b0, xb, 1'b0, 1'b1}) begin
        fail_cnt++;
        $display("FAIL %s back_idle: rxv/rxd/busy/ready got %b want %b", name,
                 {o_rxv, o_rxd, o_busy, o_ready}, {1'b0, xb, 1'b0, 1'b1});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; tx_valid = 1'b0; tx_data = '0; x = 1'b0; abort = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    assert_cnt++;
    if ({sr_a, rxd_a, rxv_a, busy_a, ready_a, sr_b, rxd_b, rxv_b, busy_b, ready_b} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_state: a/b outputs got %b want all zero",
               {sr_a, rxd_a, rxv_a, busy_a, ready_a, sr_b, rxd_b, rxv_b, busy_b, ready_b});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    assert_cnt++;
    if ({ready_a, ready_b, busy_a, busy_b} !== 4'b1100) begin
      fail_cnt++;
      $display("FAIL reset_release: ready_a/ready_b/busy_a/busy_b got %b want 1100",
               {ready_a, ready_b, busy_a, busy_b});
    end
    last_rx[0] = '0;
    last_rx[1] = '0;
  endtask

  task automatic test_reset_mid();
    sel = 0;
    tx_data = 4'b1001; tx_valid = 1'b1;
    wait_ready("reset_mid");
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    assert_cnt++;
    if ({o_sr, o_rxv, o_busy, o_ready, o_rxd} !== {{W{1'b0}}, 3'b000, {W{1'b0}}}) begin
      fail_cnt++;
      $display("FAIL reset_mid: sr/rxv/busy/ready/rxd got %b want all zero",
               {o_sr, o_rxv, o_busy, o_ready, o_rxd});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    assert_cnt++;
    if (o_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_mid_release: tx_ready got %b want 1", o_ready);
    end
    last_rx[0] = '0;
    last_rx[1] = '0;
  endtask

  // Two words offered back to back: transfer period is W*DIV+2 = 6 cycles.
  task automatic test_back_to_back();
    logic [W-1:0] da, db, xa, xb2;
    logic         e_ready, e_rxv;
    sel = 0;
    da = 4'hA; db = 4'h5;
    xa = W'($urandom); xb2 = W'($urandom);
    tx_data = da; tx_valid = 1'b1;
    wait_ready("b2b");
    @(posedge clk); #1;
    tx_data = db;
    for (int c = 1; c <= 12; c++) begin
      x = (c <= 4) ? xa[W-c] : ((c >= 7 && c <= 10) ? xb2[W-(c-6)] : 1'b0);
      if (c == 7) tx_valid = 1'b0;
      @(negedge clk);
      e_ready = (c == 6) || (c == 12);
      e_rxv   = (c == 5) || (c == 11);
      assert_cnt++;
      if ({o_ready, o_busy, o_rxv} !== {e_ready, !e_ready, e_rxv}) begin
        fail_cnt++;
        $display("FAIL b2b cycle %0d: ready/busy/rxv got %b want %b", c,
                 {o_ready, o_busy, o_rxv}, {e_ready, !e_ready, e_rxv});
      end
      if (c <= 4 || (c >= 7 && c <= 10)) begin
        assert_cnt++;
        if (o_sd !== ((c <= 4) ? da[W-c] : db[W-(c-6)])) begin
          fail_cnt++;
          $display("FAIL b2b_sd cycle %0d: sd got %b want %b", c, o_sd,
                   (c <= 4) ? da[W-c] : db[W-(c-6)]);
        end
      end
      if (c == 5 || c == 11) begin
        assert_cnt++;
        if (o_rxd !== ((c == 5) ? xa : xb2)) begin
          fail_cnt++;
          $display("FAIL b2b_rxd cycle %0d: rx_data got %h want %h", c, o_rxd,
                   (c == 5) ? xa : xb2);
        end
      end
      @(posedge clk); #1;
    end
    x = 1'b0;
    last_rx[0] = xb2;
  endtask

  task automatic test_random();
    int ab;
    for (int i = 0; i < 20; i++) begin
      sel = int'($urandom_range(0, 1));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W * div_of(sel))) : 0;
      run_transfer(W'($urandom), W'($urandom), ab, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    sel = 0; run_transfer(4'b1011, 4'b0110, 0, 1'b0, "div1_basic");
    sel = 1; run_transfer(4'b1100, 4'b1111, 0, 1'b0, "div3_basic");
    sel = 0; run_transfer(4'b1111, 4'b1010, 2, 1'b0, "abort_mid");
    sel = 0; run_transfer(4'b1111, 4'b0101, 4, 1'b0, "abort_final_tick");
    sel = 1; run_transfer(4'b0110, 4'b1001, 12, 1'b0, "abort_final_tick_div3");
    test_reset_mid();
    test_back_to_back();
    sel = 0; run_transfer(W'($urandom), W'($urandom), 0, 1'b1, "tx_noise_div1");
    sel = 1; run_transfer(W'($urandom), W'($urandom), 0, 1'b1, "tx_noise_div3");
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
